wb_commit_arbiter: RTL and testbench

//  Shares the single GPR writeback port and the commit/difftest strobe of the commit stage among
//  NUM_REQ completing units (ALU, MDU, LSU). Round-robin grant with a one-cycle registered output

---
 rtl/wb_commit_arbiter_pkg.sv | 31 +++
 rtl/wb_commit_arbiter_if.sv | 50 +++++
 rtl/wb_commit_arbiter_rr_arbiter.sv | 85 ++++++++
 rtl/wb_commit_arbiter.sv | 111 +++++++++++
 tb/tb_wb_commit_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_commit_arbiter_pkg
//   Shared constants and types for the writeback/commit arbiter.
//   - XLEN, INST_W, REG_ADDR_W : datapath widths
//   - NUM_REQ_DEF              : default number of completing units
//   - wb_req_t                 : one completing instruction's writeback payload
//   - writes_gpr()             : true when a payload really writes a GPR (x0 excluded)
// ----------------------------------------------------------------------------
package wb_commit_arbiter_pkg;

    localparam int XLEN        = 64;
    localparam int INST_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int CNT_W       = 64;
    localparam int NUM_REQ_DEF = 3;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_data;
        logic [XLEN-1:0]       pc;
        logic [INST_W-1:0]     inst;
        logic                  peripheral;
    } wb_req_t;

    // x0 is hardwired to zero, so a write to it is dropped but still retires.
    function automatic logic writes_gpr(input wb_req_t r);
        return r.wen & (r.rd_addr != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_commit_arbiter_if
//   Bundle between the completing units (ALU/MDU/LSU), the upstream control
//   (hold/flush) and the commit stage.
//   master : upstream side -- drives requests/hold/flush, observes grants and
//            the commit-stage outputs.
//   slave  : the arbiter -- consumes requests, drives req_ready and outputs.
//   Per-requester fields are flattened; slice i of a W-bit field is [W*i +: W].
// ----------------------------------------------------------------------------
interface wb_commit_arbiter_if
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wen;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_addr;
    logic [NUM_REQ*XLEN-1:0]       req_rd_data;
    logic [NUM_REQ*XLEN-1:0]       req_pc;
    logic [NUM_REQ*INST_W-1:0]     req_inst;
    logic [NUM_REQ-1:0]            req_peripheral;
    logic                          hold;
    logic                          flush;

    logic                          wb_valid;
    logic [REG_ADDR_W-1:0]         wb_dest_addr;
    logic [XLEN-1:0]               wb_dest_data;
    logic                          commit;
    logic [XLEN-1:0]               commit_pc;
    logic [INST_W-1:0]             commit_inst;
    logic                          commit_peripheral;
    logic [CNT_W-1:0]              commit_count;

    modport master (
        output req_valid, req_wen, req_rd_addr, req_rd_data, req_pc, req_inst,
               req_peripheral, hold, flush,
        input  req_ready, wb_valid, wb_dest_addr, wb_dest_data, commit,
               commit_pc, commit_inst, commit_peripheral, commit_count
    );

    modport slave (
        input  req_valid, req_wen, req_rd_addr, req_rd_data, req_pc, req_inst,
               req_peripheral, hold, flush,
        output req_ready, wb_valid, wb_dest_addr, wb_dest_data, commit,
               commit_pc, commit_inst, commit_peripheral, commit_count
    );

endinterface

// File: rtl/wb_commit_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Generic N-way round-robin arbiter with a combinational one-hot grant.
//   Ports:
//     clock, reset : clock, synchronous active-high reset (pointer -> 0)
//     req_i[N]     : request vector
//     advance_i    : grants allowed this cycle; when low grant_o is all-zero
//     grant_o[N]   : one-hot grant to the first requester at/after the pointer
//   After a grant to i the pointer moves to (i+1) mod N, which bounds any
//   waiting requester to at most N-1 other grants before its own.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N-1:0]     req_hi_s;
    logic [N-1:0]     req_sel_s;
    logic [N-1:0]     grant_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic             found_s;

    // Priority pick: requests at/after the pointer win; otherwise wrap to the lowest index.
    always_comb begin
        req_hi_s    = {N{1'b0}};
        grant_s     = {N{1'b0}};
        grant_idx_s = ptr_q;
        found_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr_q)) begin
                req_hi_s[i] = req_i[i];
            end else begin
                req_hi_s[i] = 1'b0;
            end
        end
        if (|req_hi_s) begin
            req_sel_s = req_hi_s;
        end else begin
            req_sel_s = req_i;
        end
        for (int i = 0; i < N; i++) begin
            if (advance_i && !found_s && req_sel_s[i]) begin
                grant_s[i]  = 1'b1;
                grant_idx_s = PTR_W'(i);
                found_s     = 1'b1;
            end else begin
                grant_s[i]  = grant_s[i];
            end
        end
    end

    // Pointer next-state: step past the winner only when a grant was issued.
    always_comb begin
        if (found_s) begin
            if (grant_idx_s == PTR_W'(N - 1)) begin
                ptr_d = {PTR_W{1'b0}};
            end else begin
                ptr_d = grant_idx_s + PTR_W'(1'b1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= {PTR_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o = grant_s;

endmodule

// File: rtl/wb_commit_arbiter.sv
// ----------------------------------------------------------------------------
// wb_commit_arbiter
//   Shares the single GPR writeback port and the commit strobe among NUM_REQ
//   completing units. Round-robin grant (combinational req_ready), payload
//   captured on the grant edge and presented to the commit stage one cycle
//   later, plus a 64-bit retired-instruction counter.
//   Ports:
//     clock : system clock
//     reset : synchronous, active-high
//     bus   : wb_commit_arbiter_if.slave (requests, hold/flush, commit outputs)
// ----------------------------------------------------------------------------
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    wb_commit_arbiter_if.slave   bus
);

    logic [NUM_REQ-1:0] grant_s;
    logic               advance_s;
    wb_req_t            req_s [NUM_REQ];
    wb_req_t            sel_s;

    logic               commit_q,   commit_d;
    logic               wb_valid_q, wb_valid_d;
    wb_req_t            payload_q,  payload_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    // flush dominates hold; both simply suppress the grant. Reset also blocks
    // grants so no requester sees ready while the arbiter is being cleared.
    assign advance_s = !reset && !bus.hold && !bus.flush;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_i     (bus.req_valid),
        .advance_i (advance_s),
        .grant_o   (grant_s)
    );

    assign bus.req_ready = grant_s;

    // Unflatten the per-requester payload slices into structs.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s[i].wen        = bus.req_wen[i];
            req_s[i].rd_addr    = bus.req_rd_addr[i*REG_ADDR_W +: REG_ADDR_W];
            req_s[i].rd_data    = bus.req_rd_data[i*XLEN +: XLEN];
            req_s[i].pc         = bus.req_pc[i*XLEN +: XLEN];
            req_s[i].inst       = bus.req_inst[i*INST_W +: INST_W];
            req_s[i].peripheral = bus.req_peripheral[i];
        end
    end

    // AND-OR payload mux; the grant is one-hot so at most one term is live.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_s = sel_s | req_s[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Output-stage next state: strobes follow the grant, data fields hold when idle.
    always_comb begin
        if (|grant_s) begin
            commit_d   = 1'b1;
            wb_valid_d = writes_gpr(sel_s);
            payload_d  = sel_s;
            count_d    = count_q + 64'd1;
        end else begin
            commit_d   = 1'b0;
            wb_valid_d = 1'b0;
            payload_d  = payload_q;
            count_d    = count_q;
        end
    end

    // Output-stage and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            commit_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            payload_q  <= '0;
            count_q    <= {CNT_W{1'b0}};
        end else begin
            commit_q   <= commit_d;
            wb_valid_q <= wb_valid_d;
            payload_q  <= payload_d;
            count_q    <= count_d;
        end
    end

    assign bus.commit            = commit_q;
    assign bus.wb_valid          = wb_valid_q;
    assign bus.wb_dest_addr      = payload_q.rd_addr;
    assign bus.wb_dest_data      = payload_q.rd_data;
    assign bus.commit_pc         = payload_q.pc;
    assign bus.commit_inst       = payload_q.inst;
    assign bus.commit_peripheral = payload_q.peripheral;
    assign bus.commit_count      = count_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_commit_arbiter
//   Directed table of vectors with hand-computed grants and commit-stage
//   results, followed by a hand-written reset-in-flight sequence.
//   Each requester carries a fixed data/pc/inst/peripheral payload; the table
//   names which requester's payload should be visible (3 = all-zero, after reset).
// ----------------------------------------------------------------------------
module tb_wb_commit_arbiter;

    logic clk;
    logic rst;

    wb_commit_arbiter_if #(.NUM_REQ(3)) bus ();

    wb_commit_arbiter #(.NUM_REQ(3)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic        hold;
        logic        flush;
        logic [2:0]  wen;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic [2:0]  exp_ready;
        logic        exp_commit;
        logic        exp_wbv;
        logic [4:0]  exp_addr;
        int          exp_src;
        logic [63:0] exp_count;
    } vec_t;

    vec_t        vecs [20];
    logic [63:0] tab_data [4];
    logic [63:0] tab_pc   [4];
    logic [31:0] tab_inst [4];
    logic        tab_per  [4];

    int n_vec;
    int n_miscmp;

    function automatic vec_t mk(input logic [2:0] v, input logic h, input logic f,
                                input logic [2:0] w, input logic [4:0] r0,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] er, input logic ec, input logic ew,
                                input logic [4:0] ea, input int es, input logic [63:0] cnt);
        vec_t t;
        t.valid = v; t.hold = h; t.flush = f; t.wen = w;
        t.rd0 = r0; t.rd1 = r1; t.rd2 = r2;
        t.exp_ready = er; t.exp_commit = ec; t.exp_wbv = ew;
        t.exp_addr = ea; t.exp_src = es; t.exp_count = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic h, input logic f,
                         input logic [2:0] w, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.req_valid   = v;
        bus.hold        = h;
        bus.flush       = f;
        bus.req_wen     = w;
        bus.req_rd_addr = {r2, r1, r0};
    endtask

    task automatic chk_outputs(input int idx, input logic ec, input logic ew,
                               input logic [4:0] ea, input int es, input logic [63:0] cnt);
        chk("commit",     idx, {63'd0, bus.commit},            {63'd0, ec});
        chk("wb_valid",   idx, {63'd0, bus.wb_valid},          {63'd0, ew});
        chk("dest_addr",  idx, {59'd0, bus.wb_dest_addr},      {59'd0, ea});
        chk("dest_data",  idx, bus.wb_dest_data,               tab_data[es]);
        chk("commit_pc",  idx, bus.commit_pc,                  tab_pc[es]);
        chk("commit_inst",idx, {32'd0, bus.commit_inst},       {32'd0, tab_inst[es]});
        chk("peripheral", idx, {63'd0, bus.commit_peripheral}, {63'd0, tab_per[es]});
        chk("count",      idx, bus.commit_count,               cnt);
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;

        tab_data[0] = 64'h0000_0000_0000_A0A0; tab_pc[0] = 64'h0000_0000_8000_0000;
        tab_data[1] = 64'h0000_0000_0000_DEAD; tab_pc[1] = 64'h0000_0000_8000_0004;
        tab_data[2] = 64'h0000_0000_0000_BEEF; tab_pc[2] = 64'h0000_0000_8000_0008;
        tab_data[3] = 64'h0;                   tab_pc[3] = 64'h0;
        tab_inst[0] = 32'h0000_0013; tab_per[0] = 1'b0;
        tab_inst[1] = 32'h0010_0093; tab_per[1] = 1'b0;
        tab_inst[2] = 32'h0020_0113; tab_per[2] = 1'b1;
        tab_inst[3] = 32'h0;         tab_per[3] = 1'b0;

        // idle after reset
        vecs[0]  = mk(3'b000,1'b0,1'b0,3'b000,5'd0,5'd0,5'd0, 3'b000,1'b0,1'b0,5'd0,3, 64'd0);
        // lone req1: rd5 / 0xDEAD / 0x80000004
        vecs[1]  = mk(3'b010,1'b0,1'b0,3'b010,5'd0,5'd5,5'd0, 3'b010,1'b1,1'b1,5'd5,1, 64'd1);
        vecs[2]  = mk(3'b000,1'b0,1'b0,3'b000,5'd0,5'd0,5'd0, 3'b000,1'b0,1'b0,5'd5,1, 64'd1);
        // pointer is at 2: req2 alone brings it back to 0
        vecs[3]  = mk(3'b100,1'b0,1'b0,3'b100,5'd0,5'd0,5'd3, 3'b100,1'b1,1'b1,5'd3,2, 64'd2);
        // all valid for six cycles: 0,1,2,0,1,2 back to back
        vecs[4]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b001,1'b1,1'b1,5'd1,0, 64'd3);
        vecs[5]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b010,1'b1,1'b1,5'd2,1, 64'd4);
        vecs[6]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b100,1'b1,1'b1,5'd3,2, 64'd5);
        vecs[7]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b001,1'b1,1'b1,5'd1,0, 64'd6);
        vecs[8]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b010,1'b1,1'b1,5'd2,1, 64'd7);
        vecs[9]  = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b100,1'b1,1'b1,5'd3,2, 64'd8);
        // x0 target with wen=1, then wen=0: retire without a GPR write
        vecs[10] = mk(3'b001,1'b0,1'b0,3'b001,5'd0,5'd0,5'd0, 3'b001,1'b1,1'b0,5'd0,0, 64'd9);
        vecs[11] = mk(3'b100,1'b0,1'b0,3'b000,5'd0,5'd0,5'd7, 3'b100,1'b1,1'b0,5'd7,2, 64'd10);
        // grant req0, flush, then req1 next
        vecs[12] = mk(3'b111,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b001,1'b1,1'b1,5'd1,0, 64'd11);
        vecs[13] = mk(3'b110,1'b0,1'b1,3'b111,5'd1,5'd2,5'd3, 3'b000,1'b0,1'b0,5'd1,0, 64'd11);
        vecs[14] = mk(3'b110,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b010,1'b1,1'b1,5'd2,1, 64'd12);
        // hold for three cycles with req2 waiting, then release
        vecs[15] = mk(3'b100,1'b1,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b000,1'b0,1'b0,5'd2,1, 64'd12);
        vecs[16] = mk(3'b100,1'b1,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b000,1'b0,1'b0,5'd2,1, 64'd12);
        vecs[17] = mk(3'b100,1'b1,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b000,1'b0,1'b0,5'd2,1, 64'd12);
        vecs[18] = mk(3'b100,1'b0,1'b0,3'b111,5'd1,5'd2,5'd3, 3'b100,1'b1,1'b1,5'd3,2, 64'd13);
        // hold and flush together
        vecs[19] = mk(3'b111,1'b1,1'b1,3'b111,5'd1,5'd2,5'd3, 3'b000,1'b0,1'b0,5'd3,2, 64'd13);

        bus.req_rd_data    = {tab_data[2], tab_data[1], tab_data[0]};
        bus.req_pc         = {tab_pc[2], tab_pc[1], tab_pc[0]};
        bus.req_inst       = {tab_inst[2], tab_inst[1], tab_inst[0]};
        bus.req_peripheral = 3'b100;
        drive(3'b000, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].valid, vecs[i].hold, vecs[i].flush, vecs[i].wen,
                  vecs[i].rd0, vecs[i].rd1, vecs[i].rd2);
            n_vec++;
            #1;
            chk("req_ready", i, {61'd0, bus.req_ready}, {61'd0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk_outputs(i, vecs[i].exp_commit, vecs[i].exp_wbv, vecs[i].exp_addr,
                        vecs[i].exp_src, vecs[i].exp_count);
            @(negedge clk);
        end

        // Reset arriving while all requesters wait: grant dropped, outputs cleared.
        drive(3'b111, 1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3);
        rst = 1'b1;
        n_vec++;
        #1;
        chk("ready_in_reset", 100, {61'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk_outputs(100, 1'b0, 1'b0, 5'd0, 3, 64'd0);

        // Out of reset the pointer is back at 0.
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        #1;
        chk("ready_after_reset", 101, {61'd0, bus.req_ready}, {61'd0, 3'b001});
        @(posedge clk);
        #1;
        chk_outputs(101, 1'b1, 1'b1, 5'd1, 0, 64'd1);

        @(negedge clk);
        n_vec++;
        #1;
        chk("ready_rotate", 102, {61'd0, bus.req_ready}, {61'd0, 3'b010});
        @(posedge clk);
        #1;
        chk_outputs(102, 1'b1, 1'b1, 5'd2, 1, 64'd2);

        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
